// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM read arbiter: FSM encoding,
// master index width and latency counter width.
package vram_arb_pkg;

   localparam int MAX_MASTERS = 4;
   localparam int IDX_W       = $clog2(MAX_MASTERS);
   localparam int CNT_W       = 2;

   typedef enum logic {
      STATE_IDLE = 1'b0,
      STATE_WAIT = 1'b1
   } state_t;

   // Wrapping increment of a master index, used to advance the round-robin pointer.
   function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx, input int n);
      return (int'(idx) == n - 1) ? '0 : idx + IDX_W'(1);
   endfunction

endpackage

// File: rtl/vram_arb_select.sv
// Combinational winner selection among eligible masters.
// VRAM_ARB_ROUND_ROBIN_EN selects round-robin search from rr_ptr; otherwise index 0 has highest priority.
module vram_arb_select
   import vram_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 3
)
(
   input  logic [NUM_MASTERS-1:0] eligible,
   input  logic [IDX_W-1:0]       rr_ptr,
   output logic [IDX_W-1:0]       winner,
   output logic                   valid
);

`ifdef VRAM_ARB_ROUND_ROBIN_EN
   int                     idx;
   logic [NUM_MASTERS-1:0] probe;

   // Walk the offsets backwards so the eligible master closest to rr_ptr is assigned last and wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = 0;
      probe  = '0;
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
         idx   = (int'(rr_ptr) + k) % NUM_MASTERS;
         probe = eligible >> idx;
         if (probe[0]) begin
            winner = IDX_W'(idx);
            valid  = 1'b1;
         end
      end
   end
`else
   logic unused_rr;
   assign unused_rr = ^rr_ptr;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = IDX_W'(i);
            valid  = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/vram_read_arbiter.sv
// Arbitrates NUM_MASTERS renderer read requests onto one synchronous VRAM read port
// and returns each word with a one-cycle ack. Optional macro: VRAM_ARB_ROUND_ROBIN_EN.
module vram_read_arbiter
   import vram_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_W      = 16,
   parameter int RAM_LATENCY = 1
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [NUM_MASTERS-1:0]        m_strobe,
   output logic [NUM_MASTERS-1:0]        m_ack,
   output logic [31:0]                   m_rddata,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic                          ram_rden,
   input  logic [31:0]                   ram_rddata
);

   state_t                 state;
   logic [IDX_W-1:0]       grant;
   logic [IDX_W-1:0]       rr_ptr;
   logic [IDX_W-1:0]       winner;
   logic                   winner_valid;
   logic [CNT_W-1:0]       cnt;
   logic                   cancel;
   logic [NUM_MASTERS-1:0] eligible;
   logic [NUM_MASTERS-1:0] grant_mask;
   logic                   strobe_lost;

   // The master being acked this cycle is never re-granted in the same cycle.
   assign eligible    = (state == STATE_IDLE) ? (m_strobe & ~m_ack) : '0;
   assign grant_mask  = NUM_MASTERS'(1) << grant;
   assign strobe_lost = ~|(m_strobe & grant_mask);

   vram_arb_select #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_select (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .winner   (winner),
      .valid    (winner_valid)
   );

   // WAIT spans RAM_LATENCY+1 cycles; the last one is when ram_rddata is valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= STATE_IDLE;
         grant    <= '0;
         rr_ptr   <= '0;
         cnt      <= '0;
         cancel   <= 1'b0;
         m_ack    <= '0;
         m_rddata <= '0;
         ram_addr <= '0;
         ram_rden <= 1'b0;
      end else begin
         m_ack    <= '0;
         ram_rden <= 1'b0;
         case (state)
            STATE_IDLE: begin
               if (winner_valid) begin
                  grant    <= winner;
                  rr_ptr   <= next_index(winner, NUM_MASTERS);
                  ram_addr <= m_addr[winner*ADDR_W +: ADDR_W];
                  ram_rden <= 1'b1;
                  cnt      <= CNT_W'(RAM_LATENCY);
                  cancel   <= 1'b0;
                  state    <= STATE_WAIT;
               end
            end
            STATE_WAIT: begin
               if (cnt == '0) begin
                  m_rddata <= ram_rddata;
                  m_ack    <= (cancel | strobe_lost) ? '0 : grant_mask;
                  cancel   <= 1'b0;
                  state    <= STATE_IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  if (strobe_lost) begin
                     cancel <= 1'b1;
                  end
               end
            end
            default: state <= STATE_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_read_arbiter.sv
// Self-checking bench for vram_read_arbiter: transaction-timeline reference model,
// a per-cycle compare process, directed literal checks and randomized masters.
module tb_vram_read_arbiter;

   localparam int NM  = 3;
   localparam int AW  = 16;
   localparam int LAT = 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [NM*AW-1:0] m_addr;
   logic [NM-1:0]    m_strobe;
   logic [NM-1:0]    m_ack;
   logic [31:0]      m_rddata;
   logic [AW-1:0]    ram_addr;
   logic             ram_rden;
   logic [31:0]      ram_rddata;
   logic [AW-1:0]    maddr [NM];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   bit chk_en      = 1'b0;

   typedef struct {
      logic [NM-1:0] ack;
      logic          rden;
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } exp_t;

   exp_t ring [8];

   // Reference model state: one outstanding access described by its grant cycle.
   bit            busy = 1'b0;
   bit            pcancel = 1'b0;
   int            g_cyc = 0;
   int            pm = 0;
   int            rr = 0;
   logic [AW-1:0] paddr = '0;
   logic [AW-1:0] last_addr = '0;
   logic [31:0]   last_data = '0;

   int            ack_who [8];
   int            ack_when [8];
   int            n_acks;

   always #5 clk = ~clk;

   always_comb begin
      m_addr = '0;
      for (int i = 0; i < NM; i++) m_addr[i*AW +: AW] = maddr[i];
   end

   vram_read_arbiter #(
      .NUM_MASTERS (NM),
      .ADDR_W      (AW),
      .RAM_LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .m_addr     (m_addr),
      .m_strobe   (m_strobe),
      .m_ack      (m_ack),
      .m_rddata   (m_rddata),
      .ram_addr   (ram_addr),
      .ram_rden   (ram_rden),
      .ram_rddata (ram_rddata)
   );

   function automatic logic [31:0] ram_func(input logic [AW-1:0] a);
      if (a == 16'h1234) return 32'hDEADBEEF;
      return {a ^ 16'hA5C3, a};
   endfunction

   // VRAM macro: data appears LAT cycles after the read enable, garbage otherwise.
   logic [31:0] pipe [1:3];
   always @(posedge clk) begin
      pipe[1] <= ram_rden ? ram_func(ram_addr) : $urandom;
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
   end
   assign ram_rddata = pipe[LAT];

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         compare("m_ack", 32'(m_ack), 32'(ring[cyc%8].ack));
         compare("ram_rden", 32'(ram_rden), 32'(ring[cyc%8].rden));
         compare("ram_addr", 32'(ram_addr), 32'(ring[cyc%8].addr));
         compare("m_rddata", m_rddata, ring[cyc%8].data);
      end
   end

   // Decide what the outputs must be next cycle from this cycle's inputs.
   task automatic model_eval();
      exp_t          e;
      logic [NM-1:0] elig;
      int            start;
      int            w;
      int            i;
      e.ack  = '0;
      e.rden = 1'b0;
      w      = -1;
      if (rst) begin
         busy      = 1'b0;
         rr        = 0;
         last_addr = '0;
         last_data = '0;
      end else if (busy) begin
         if (!m_strobe[pm]) pcancel = 1'b1;
         if (cyc == g_cyc + 1 + LAT) begin
            busy      = 1'b0;
            last_data = ram_func(paddr);
            if (!pcancel) e.ack[pm] = 1'b1;
         end
      end else begin
         elig = m_strobe & ~ring[cyc%8].ack;
`ifdef VRAM_ARB_ROUND_ROBIN_EN
         start = rr;
`else
         start = 0;
`endif
         for (int k = 0; k < NM; k++) begin
            i = (start + k) % NM;
            if (w < 0 && elig[i]) w = i;
         end
         if (w >= 0) begin
            busy      = 1'b1;
            pcancel   = 1'b0;
            g_cyc     = cyc;
            pm        = w;
            paddr     = maddr[w];
            last_addr = paddr;
            e.rden    = 1'b1;
            rr        = (w + 1) % NM;
         end
      end
      e.addr = last_addr;
      e.data = last_data;
      ring[(cyc+1)%8] = e;
   endtask

   task automatic tick();
      model_eval();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Masters hold strobe until ack and drop it in the ack cycle, optionally re-strobing at once.
   task automatic apply_agents(input logic [NM-1:0] enable, input int start_pct,
                               input int abort_pct, input int restrobe_pct);
      logic [NM-1:0] ack_now;
      ack_now = ring[cyc%8].ack;
      for (int i = 0; i < NM; i++) begin
         if (m_strobe[i]) begin
            if (ack_now[i]) begin
               m_strobe[i] = 1'b0;
               if (enable[i] && $urandom_range(99, 0) < restrobe_pct) begin
                  m_strobe[i] = 1'b1;
                  maddr[i]    = AW'($urandom);
               end
            end else if (!enable[i] || $urandom_range(99, 0) < abort_pct) begin
               m_strobe[i] = 1'b0;
            end
         end else if (enable[i] && $urandom_range(99, 0) < start_pct) begin
            m_strobe[i] = 1'b1;
            maddr[i]    = AW'($urandom);
         end
      end
   endtask

   task automatic record_ack();
      for (int i = 0; i < NM; i++) begin
         if (m_ack[i] === 1'b1 && n_acks < 8) begin
            ack_who[n_acks]  = i;
            ack_when[n_acks] = cyc;
            n_acks++;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         ring[i].ack  = '0;
         ring[i].rden = 1'b0;
         ring[i].addr = '0;
         ring[i].data = '0;
      end
      for (int i = 0; i < NM; i++) maddr[i] = '0;
      rst      = 1'b1;
      m_strobe = '0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      compare("reset_m_ack", 32'(m_ack), 32'd0);
      compare("reset_ram_rden", 32'(ram_rden), 32'd0);
      compare("reset_m_rddata", m_rddata, 32'd0);

      // Single request from the sprite renderer.
      maddr[0] = 16'h1234;
      m_strobe = 3'b001;
      tick();
      compare("single_rden", 32'(ram_rden), 32'd1);
      compare("single_addr", 32'(ram_addr), 32'h1234);
      tick();
      compare("single_no_early_ack", 32'(m_ack), 32'd0);
      tick();
      compare("single_ack", 32'(m_ack), 32'b001);
      compare("single_data", m_rddata, 32'hDEADBEEF);
      m_strobe = '0;
      repeat (3) tick();

      // Contention from a clean reset so the round-robin pointer starts at 0.
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      n_acks = 0;
      for (int k = 0; k < 16; k++) begin
         apply_agents(3'b111, 100, 0, 0);
         tick();
         record_ack();
      end
      compare("contention_ack_count", 32'(n_acks >= 4), 32'd1);
`ifdef VRAM_ARB_ROUND_ROBIN_EN
      compare("rr_ack0", 32'(ack_who[0]), 32'd0);
      compare("rr_ack1", 32'(ack_who[1]), 32'd1);
      compare("rr_ack2", 32'(ack_who[2]), 32'd2);
      compare("rr_ack3", 32'(ack_who[3]), 32'd0);
`else
      compare("fixed_ack0", 32'(ack_who[0]), 32'd0);
      compare("fixed_ack1", 32'(ack_who[1]), 32'd1);
      compare("fixed_ack2", 32'(ack_who[2]), 32'd0);
      compare("fixed_ack3", 32'(ack_who[3]), 32'd1);
`endif
      for (int k = 0; k < 3; k++) begin
         compare("contention_spacing", 32'(ack_when[k+1] - ack_when[k]), 32'd3);
      end
      for (int k = 0; k < 12; k++) begin
         apply_agents(3'b110, 100, 0, 0);
         tick();
      end
      for (int k = 0; k < 8; k++) begin
         apply_agents(3'b000, 0, 0, 0);
         tick();
      end

      // Master 1 aborts its fetch while in flight, then re-requests.
      maddr[1] = 16'h0BAD;
      m_strobe = 3'b010;
      tick();
      tick();
      m_strobe = 3'b000;
      tick();
      compare("cancel_no_ack", 32'(m_ack), 32'd0);
      repeat (3) tick();
      maddr[1] = 16'h0042;
      m_strobe = 3'b010;
      repeat (3) tick();
      compare("cancel_reack", 32'(m_ack), 32'b010);
      compare("cancel_reack_data", m_rddata, 32'hA5810042);
      m_strobe = '0;
      repeat (2) tick();

      // Reset lands while an access is in WAIT.
      maddr[2] = 16'h7777;
      m_strobe = 3'b100;
      tick();
      rst = 1'b1;
      tick();
      compare("midrst_m_ack", 32'(m_ack), 32'd0);
      compare("midrst_rden", 32'(ram_rden), 32'd0);
      rst      = 1'b0;
      m_strobe = '0;
      repeat (4) tick();
      maddr[0] = 16'h1234;
      m_strobe = 3'b001;
      repeat (3) tick();
      compare("midrst_new_ack", 32'(m_ack), 32'b001);
      compare("midrst_new_data", m_rddata, 32'hDEADBEEF);
      m_strobe = '0;
      repeat (2) tick();

      // Randomized traffic with aborts, ack-cycle re-strobes and occasional resets.
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(399, 0) == 0);
         apply_agents(3'b111, 30, 3, 25);
         tick();
      end
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         apply_agents(3'b000, 0, 0, 0);
         tick();
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
